// File: rtl/ad7606_pkg.sv
// ad7606_pkg: state encoding, channel geometry and tick-derivation helpers
// shared by the AD7606 emulator. Revision 1.0.
`default_nettype none

package ad7606_pkg;

  localparam int NUM_CH      = 8;
  localparam int WORD_W      = 16;
  localparam int IDX_W       = $clog2(NUM_CH) + 1;
  localparam int MS_PER_S    = 1_000;
  localparam int POWER_ON_MS = 30;

  typedef enum logic [2:0] {
    OFF     = 3'd0,
    POWERUP = 3'd1,
    IDLE    = 3'd2,
    CONVERT = 3'd3,
    READ    = 3'd4
  } state_t;

  // One spare bit so a counter never wraps before its terminal count.
  function automatic int ticks_w(input int ticks);
    return $clog2(ticks) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ad7606_edge_det.sv
// ad7606_edge_det: registered rise/fall detector comparing a strobe with its
// value from the previous cycle. Revision 1.0.
`default_nettype none

module ad7606_edge_det #(
  parameter logic INIT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic rise,
  output logic fall
);

  logic prev;

  always_ff @(posedge clk) begin
    if (rst) prev <= INIT;
    else     prev <= sig;
  end

  assign rise = sig & ~prev;
  assign fall = ~sig & prev;

endmodule

`default_nettype wire

// File: rtl/ad7606_emulator.sv
// ad7606_emulator: behavioural model of the AD7606 parallel-interface ADC
// (power-up delay, BUSY-timed conversion, eight-word RD_N readout). Revision 1.0.
`default_nettype none

module ad7606_emulator
  import ad7606_pkg::*;
#(
  parameter int CLK_FREQUENCY  = 30_000_000,
  parameter int POWER_ON_TICKS = CLK_FREQUENCY / MS_PER_S * POWER_ON_MS,
  parameter int CONV_TICKS     = 120
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         power,
  input  logic         dev_reset,
  input  logic         convst,
  input  logic         cs_n,
  input  logic         rd_n,
  input  logic [127:0] ch_sample,
  output logic         busy,
  output logic         frstdata,
  output logic [15:0]  db,
  output logic         db_oe
);

  localparam int PWR_W  = ticks_w(POWER_ON_TICKS);
  localparam int CONV_W = ticks_w(CONV_TICKS);

  state_t                         state, state_nx;
  logic [PWR_W-1:0]               pwr_cnt;
  logic [CONV_W-1:0]              conv_cnt;
  logic [IDX_W-1:0]               idx;
  logic [NUM_CH-1:0][WORD_W-1:0]  data;

  logic convst_rise, rd_rise;
  logic convst_fall_unused, rd_fall_unused;
  logic active, clear, start, read_ok, advance;

  ad7606_edge_det #(.INIT(1'b0)) u_convst_edge (
    .clk  (clk),
    .rst  (rst),
    .sig  (convst),
    .rise (convst_rise),
    .fall (convst_fall_unused)
  );

  ad7606_edge_det #(.INIT(1'b1)) u_rd_edge (
    .clk  (clk),
    .rst  (rst),
    .sig  (rd_n),
    .rise (rd_rise),
    .fall (rd_fall_unused)
  );

  // Priority: supply loss, then dev_reset, then a new conversion, then reads.
  assign active  = power && (state == IDLE || state == CONVERT || state == READ);
  assign clear   = active && dev_reset;
  assign start   = power && !dev_reset && convst_rise && (state == IDLE || state == READ);
  assign read_ok = power && !dev_reset && !convst_rise && (state == READ) &&
                   !cs_n && !rd_n && (idx < IDX_W'(NUM_CH));
  assign advance = power && !dev_reset && !convst_rise && (state == READ) &&
                   !cs_n && rd_rise && (idx < IDX_W'(NUM_CH));

  always_comb begin
    state_nx = state;
    if (!power) begin
      state_nx = OFF;
    end else begin
      case (state)
        OFF:     state_nx = POWERUP;
        POWERUP: if (pwr_cnt == PWR_W'(POWER_ON_TICKS - 1)) state_nx = IDLE;
        IDLE,
        READ:    begin
          if (dev_reset)        state_nx = IDLE;
          else if (convst_rise) state_nx = CONVERT;
        end
        CONVERT: begin
          if (dev_reset)                                   state_nx = IDLE;
          else if (conv_cnt == CONV_W'(CONV_TICKS - 1))   state_nx = READ;
        end
        default: state_nx = OFF;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= OFF;
      pwr_cnt  <= '0;
      conv_cnt <= '0;
      idx      <= '0;
      data     <= '0;
      db       <= '0;
      db_oe    <= 1'b0;
      frstdata <= 1'b0;
    end else begin
      state    <= state_nx;
      pwr_cnt  <= (state == POWERUP && state_nx == POWERUP) ? pwr_cnt + PWR_W'(1) : '0;
      conv_cnt <= (state == CONVERT && state_nx == CONVERT) ? conv_cnt + CONV_W'(1) : '0;

      if (clear) begin
        idx  <= '0;
        data <= '0;
      end else if (start) begin
        idx  <= '0;
        data <= ch_sample;
      end else if (advance) begin
        idx  <= idx + IDX_W'(1);
      end

      db_oe    <= read_ok;
      frstdata <= read_ok && (idx == '0);
      db       <= read_ok ? data[idx[IDX_W-2:0]] : '0;
    end
  end

  assign busy = (state == CONVERT);

endmodule

`default_nettype wire

// File: tb/tb_ad7606_emulator.sv
// tb_ad7606_emulator: directed sequence with randomised channel data, read
// counts and retrigger points, checked against a word-list readout model.
`default_nettype none

module tb_ad7606_emulator;

  localparam int P = 10;
  localparam int C = 12;

  logic         clk = 1'b0;
  logic         rst, power, dev_reset, convst, cs_n, rd_n;
  logic [127:0] ch_sample;
  logic         busy, frstdata, db_oe;
  logic [15:0]  db;

  int tests = 0;
  int fails = 0;

  // Readout model: words captured at conversion start, and how many were read.
  logic [15:0] exp_words [8];
  int          exp_idx = 8;

  ad7606_emulator #(
    .CLK_FREQUENCY  (1_000_000),
    .POWER_ON_TICKS (P),
    .CONV_TICKS     (C)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .power     (power),
    .dev_reset (dev_reset),
    .convst    (convst),
    .cs_n      (cs_n),
    .rd_n      (rd_n),
    .ch_sample (ch_sample),
    .busy      (busy),
    .frstdata  (frstdata),
    .db        (db),
    .db_oe     (db_oe)
  );

  always #5 clk = ~clk;

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic randomize_samples();
    for (int i = 0; i < 8; i++) ch_sample[i*16 +: 16] = 16'($urandom);
  endtask

  task automatic pulse_convst();
    convst = 1'b1;
    tick();
    convst = 1'b0;
  endtask

  // Accepted conversion: data captured at the edge, busy visible right after.
  task automatic start_conv(input string tag);
    randomize_samples();
    for (int i = 0; i < 8; i++) exp_words[i] = ch_sample[i*16 +: 16];
    pulse_convst();
    exp_idx = 0;
    check(tag, {31'd0, busy}, 32'd1);
    randomize_samples();
  endtask

  // Measures busy width; optional convst pulse at busy cycle retrig_at.
  task automatic wait_conv(input string tag, input int retrig_at);
    int width = 1;
    for (int n = 0; n < C + 5; n++) begin
      convst = (width == retrig_at);
      if (width < C - 3) begin
        rd_n = 1'($urandom);
        cs_n = 1'($urandom);
      end else begin
        rd_n = 1'b1;
        cs_n = 1'b1;
      end
      tick();
      check({tag, "_oe_convert"}, {31'd0, db_oe}, 32'd0);
      if (busy !== 1'b1) break;
      width++;
    end
    convst = 1'b0;
    rd_n   = 1'b1;
    cs_n   = 1'b1;
    check({tag, "_width"}, width, C);
  endtask

  task automatic do_read(input string tag);
    logic        e_oe;
    logic [15:0] e_db;
    e_oe = (exp_idx < 8);
    e_db = e_oe ? exp_words[exp_idx] : 16'd0;
    cs_n = 1'b0;
    rd_n = 1'b0;
    tick();
    check({tag, "_oe"},   {31'd0, db_oe},    {31'd0, e_oe});
    check({tag, "_db"},   {16'd0, db},       {16'd0, e_db});
    check({tag, "_frst"}, {31'd0, frstdata}, {31'd0, (e_oe && exp_idx == 0)});
    rd_n = 1'b1;
    tick();
    cs_n = 1'b1;
    check({tag, "_oe_release"}, {31'd0, db_oe}, 32'd0);
    if (e_oe) exp_idx++;
  endtask

  // Power-on from OFF: convst is ignored up to and including the IDLE-entry edge.
  task automatic power_up(input string tag);
    power = 1'b1;
    tick();
    repeat (3) tick();
    pulse_convst();
    check({tag, "_early_ignored"}, {31'd0, busy}, 32'd0);
    repeat (P - 5) tick();
    pulse_convst();
    check({tag, "_boundary_ignored"}, {31'd0, busy}, 32'd0);
    tick();
  endtask

  initial begin
    rst = 1'b1; power = 1'b0; dev_reset = 1'b0; convst = 1'b0;
    cs_n = 1'b1; rd_n = 1'b1; ch_sample = '0;
    repeat (3) tick();
    check("rst_busy",  {31'd0, busy},     32'd0);
    check("rst_oe",    {31'd0, db_oe},    32'd0);
    check("rst_db",    {16'd0, db},       32'd0);
    check("rst_frst",  {31'd0, frstdata}, 32'd0);
    rst = 1'b0;
    tick();
    pulse_convst();
    check("off_convst_ignored", {31'd0, busy}, 32'd0);
    tick();

    power_up("pu1");
    start_conv("conv1");
    wait_conv("conv1", 0);
    for (int i = 0; i < 9; i++) do_read($sformatf("read%0d", i));

    start_conv("conv2");
    wait_conv("conv2_retrig", 4);
    for (int i = 0; i < 3; i++) do_read("part");
    start_conv("conv3");
    wait_conv("conv3", 0);
    do_read("new_ch0");

    for (int r = 0; r < 3; r++) begin
      int nreads;
      start_conv("rand_conv");
      wait_conv("rand_conv", int'($urandom_range(2, C - 1)));
      nreads = int'($urandom_range(0, 9));
      for (int i = 0; i < nreads; i++) do_read("rand_read");
    end

    start_conv("conv_pl");
    repeat (3) tick();
    power = 1'b0;
    tick();
    check("powerloss_busy", {31'd0, busy}, 32'd0);
    tick();
    power_up("pu2");
    start_conv("conv_after_pu2");
    wait_conv("conv_after_pu2", 0);
    do_read("pu2_read");

    dev_reset = 1'b1;
    convst    = 1'b1;
    tick();
    dev_reset = 1'b0;
    convst    = 1'b0;
    check("devrst_busy", {31'd0, busy}, 32'd0);
    repeat (4) tick();
    check("devrst_busy_later", {31'd0, busy}, 32'd0);
    exp_idx = 8;
    do_read("devrst_read");

    start_conv("conv_dr");
    repeat (2) tick();
    dev_reset = 1'b1;
    tick();
    dev_reset = 1'b0;
    check("devrst_convert_busy", {31'd0, busy}, 32'd0);
    tick();
    start_conv("conv_after_dr");
    wait_conv("conv_after_dr", 0);

    cs_n = 1'b0;
    rd_n = 1'b0;
    tick();
    check("pre_rst_oe", {31'd0, db_oe}, 32'd1);
    rst = 1'b1;
    tick();
    check("midread_rst_busy", {31'd0, busy},     32'd0);
    check("midread_rst_oe",   {31'd0, db_oe},    32'd0);
    check("midread_rst_db",   {16'd0, db},       32'd0);
    check("midread_rst_frst", {31'd0, frstdata}, 32'd0);
    rst  = 1'b0;
    cs_n = 1'b1;
    rd_n = 1'b1;
    tick();
    pulse_convst();
    check("post_rst_convst_ignored", {31'd0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ad7606_emulator.md
AD7606_EMULATOR -- requirements
Module: ad7606_emulator

Interface
REQ-001 SHALL have parameter CLK_FREQUENCY, default 30_000_000: clk frequency in Hz.
REQ-002 SHALL have parameter POWER_ON_TICKS, default CLK_FREQUENCY/1_000*30: power-up delay in clk cycles.
REQ-003 SHALL have parameter CONV_TICKS, default 120: BUSY-high duration in clk cycles.
REQ-004 SHALL have one clock; reset is synchronous and active-high.
REQ-005 SHALL have port clk, input, 1: sole clock; all logic on posedge.
REQ-006 SHALL have port rst, input, 1: synchronous active-high reset.
REQ-007 SHALL have port power, input, 1: device supply enable; 1 = powered.
REQ-008 SHALL have port dev_reset, input, 1: emulated RESET pin, active-high.
REQ-009 SHALL have port convst, input, 1: conversion start; a rising edge starts a conversion.
REQ-010 SHALL have port cs_n, input, 1: chip select, active-low.
REQ-011 SHALL have port rd_n, input, 1: read strobe, active-low.
REQ-012 SHALL have port ch_sample, input, 128: eight 16-bit channel values; ch0 is in bits [15:0].
REQ-013 SHALL have port busy, output, 1: conversion in progress.
REQ-014 SHALL have port frstdata, output, 1: the driven word is channel 0.
REQ-015 SHALL have port db, output, 16: parallel data word.
REQ-016 SHALL have port db_oe, output, 1: db-valid and drive enable.

Function
REQ-017 SHALL implement states OFF, POWERUP, IDLE, CONVERT and READ.
REQ-018 SHALL go to OFF from any state on the cycle after power is sampled 0.
REQ-019 SHALL, in OFF, go to POWERUP when power is 1.
REQ-020 SHALL count POWERUP cycles from 0 and enter IDLE when the count reaches POWER_ON_TICKS-1; convst SHALL be ignored in OFF and POWERUP.
REQ-021 SHALL detect edges of convst and rd_n against their values registered on the previous cycle.
REQ-022 SHALL, on a convst rising edge in IDLE or READ, latch ch_sample, reset the read index to 0, enter CONVERT and assert busy on the next cycle.
REQ-023 SHALL hold busy high for exactly CONV_TICKS cycles, then enter READ with busy low.
REQ-024 SHALL ignore convst edges during CONVERT.
REQ-025 SHALL, in READ with cs_n=0, rd_n=0 and index<8, set db_oe=1 and db=latched word[index] from the cycle after rd_n is sampled low.
REQ-026 SHALL drive db=0 and db_oe=0 at all other times.
REQ-027 SHALL drive frstdata=1 exactly when db_oe=1 and index=0.
REQ-028 SHALL increment the index on an rd_n rising edge while cs_n=0 and index<8.
REQ-029 SHALL saturate the index at 8, so that further reads yield db_oe=0 until the next conversion.
REQ-030 SHALL ignore reads in any state other than READ.
REQ-031 SHALL, on dev_reset=1 in IDLE, CONVERT or READ, enter IDLE next cycle with busy=0, index=0 and latched data cleared.
REQ-032 SHALL ignore dev_reset in OFF and POWERUP.
REQ-033 SHALL, when dev_reset and a convst rising edge coincide, give dev_reset priority.
REQ-034 SHALL size the power and conversion counters as $clog2(ticks)+1 bits, with no wrap before terminal count.

Reset
REQ-035 SHALL, on rst=1, set state=OFF, all counters=0, index=0, latched data=0, busy=0, frstdata=0, db=0, db_oe=0 and edge registers=inactive (convst=0, rd_n=1).
REQ-036 SHALL give rst priority over power, dev_reset and all strobes, including a reset asserted mid-conversion or mid-read.

Structure
REQ-037 SHALL take the state enum, NUM_CH=8, WORD_W=16 and tick-derivation constants from shared package ad7606_pkg.
REQ-038 SHALL use one sub-module, ad7606_edge_det, a registered rise/fall detector instanced for convst and rd_n.

Verification
REQ-039 SHALL test power-up: POWER_ON_TICKS=10, power=1 at cycle 0, convst pulsed at cycle 5 and at cycle 12 -> first pulse ignored; busy rises at cycle 13+1 and stays high for CONV_TICKS cycles.
REQ-040 SHALL test readout: ch_sample = ch n value 0x1000+n, followed by eight cs_n/rd_n strobes -> db = 0x1000..0x1007 in order; frstdata=1 only on the first word; a ninth strobe gives db_oe=0.
REQ-041 SHALL test retrigger: convst rising during CONVERT -> busy width remains exactly CONV_TICKS; convst after 3 reads -> index restarts and the next read returns channel 0 of the new data.
REQ-042 SHALL test power loss: power=0 during CONVERT -> busy=0 on the next cycle, state OFF; re-power requires the full POWER_ON_TICKS before a conversion is accepted.
REQ-043 SHALL test dev_reset: dev_reset=1 in the same cycle as a convst rising edge in READ -> IDLE, busy stays 0, reads give db_oe=0.
REQ-044 SHALL test rst: rst=1 mid-read -> all outputs 0 next cycle, state OFF.
